// File: rtl/subleq_pkg.sv
// subleq_pkg: shared select encodings and default widths for the Subleq datapath steering blocks.
package subleq_pkg;
   localparam logic DEMUX_PORT_A = 1'b0;
   localparam logic DEMUX_PORT_B = 1'b1;
   localparam int DATA_W = 8;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output holding slot with load/drain control; transfer counter when DEMUX_CNT_EN is defined.
module demux_slot
   import subleq_pkg::*;
#(
   parameter int P_DATA = DATA_W,
   parameter int P_CNT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [P_DATA-1:0] din,
   output logic              valid,
   input  logic              ready,
   output logic [P_DATA-1:0] dout
`ifdef DEMUX_CNT_EN
   ,
   output logic [P_CNT-1:0]  count
`endif
);
   logic              r_valid;
   logic [P_DATA-1:0] r_data;
   logic              w_drain;
   assign w_drain = r_valid & ready;
   assign valid   = r_valid;
   assign dout    = r_data;
   // a load on a draining edge keeps the slot full with the new word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= load | (r_valid & ~ready);
         if (load) r_data <= din;
      end
   end
`ifdef DEMUX_CNT_EN
   logic [P_CNT-1:0] r_count;
   assign count = r_count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_count <= '0;
      else if (w_drain) r_count <= r_count + 1'b1;
   end
`else
   logic w_unused;
   assign w_unused = w_drain;
`endif
endmodule

// File: rtl/demux_stage.sv
// demux_stage: registered 1-to-2 valid/ready demultiplexer, one holding slot per channel.
// Optional per-channel transfer counters are enabled by defining DEMUX_CNT_EN.
module demux_stage
   import subleq_pkg::*;
#(
   parameter int P_DATA = DATA_W,
   parameter int P_CNT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sel,
   input  logic [P_DATA-1:0] in_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [P_DATA-1:0] a_data,
   output logic              b_valid,
   input  logic              b_ready,
   output logic [P_DATA-1:0] b_data
`ifdef DEMUX_CNT_EN
   ,
   output logic [P_CNT-1:0]  a_count,
   output logic [P_CNT-1:0]  b_count
`endif
);
   logic w_sel_b;
   logic w_accept;
   assign w_sel_b  = (in_sel == DEMUX_PORT_B);
   // readiness looks only at the addressed slot, so a stalled channel never blocks the other
   assign in_ready = w_sel_b ? (~b_valid | b_ready) : (~a_valid | a_ready);
   assign w_accept = in_valid & in_ready;
   demux_slot #(.P_DATA(P_DATA), .P_CNT(P_CNT)) u_slot_a (
      .clk   (clk),
      .rst   (rst),
      .load  (w_accept & ~w_sel_b),
      .din   (in_data),
      .valid (a_valid),
      .ready (a_ready),
      .dout  (a_data)
`ifdef DEMUX_CNT_EN
      ,
      .count (a_count)
`endif
   );
   demux_slot #(.P_DATA(P_DATA), .P_CNT(P_CNT)) u_slot_b (
      .clk   (clk),
      .rst   (rst),
      .load  (w_accept & w_sel_b),
      .din   (in_data),
      .valid (b_valid),
      .ready (b_ready),
      .dout  (b_data)
`ifdef DEMUX_CNT_EN
      ,
      .count (b_count)
`endif
   );
endmodule

// File: tb/tb_demux_stage.sv
// tb_demux_stage: table vectors, hand sequences and random traffic checked against a queue-based channel model.
module tb_demux_stage;
   logic       clk = 1'b0, rst = 1'b1;
   logic       in_valid = 1'b0, in_sel = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_ready, a_valid, b_valid;
   logic [7:0] a_data, b_data;
`ifdef DEMUX_CNT_EN
   logic [15:0] a_count, b_count;
   logic        a2_valid, b2_valid, in2_ready;
   logic [7:0]  a2_data, b2_data;
   logic [1:0]  a2_count, b2_count;
`endif
   int total = 0, bad = 0;

   demux_stage #(.P_DATA(8), .P_CNT(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data)
`ifdef DEMUX_CNT_EN
      , .a_count(a_count), .b_count(b_count)
`endif
   );
`ifdef DEMUX_CNT_EN
   demux_stage #(.P_DATA(8), .P_CNT(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in2_ready), .in_sel(in_sel), .in_data(in_data),
      .a_valid(a2_valid), .a_ready(a_ready), .a_data(a2_data),
      .b_valid(b2_valid), .b_ready(b_ready), .b_data(b2_data),
      .a_count(a2_count), .b_count(b2_count)
   );
`endif

   always #5 clk = ~clk;

   // producer rule: an offer that was not accepted must not change sel/data
   logic       p_stall = 1'b0, p_sel = 1'b0;
   logic [7:0] p_data = '0;
   always @(posedge clk) begin
      if (!rst && p_stall)
         assert (in_sel == p_sel && in_data == p_data) else $error("producer rule broken");
      p_stall <= in_valid & ~in_ready;
      p_sel   <= in_sel;
      p_data  <= in_data;
   end

   // model: each channel is a queue of at most one word; data output shows the last word loaded
   logic [7:0] qa[$], qb[$];
   logic [7:0] la = '0, lb = '0;
   int         ca = 0, cb = 0;
   bit         last_acc, last_ir;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, act, exp);
      end
   endtask

   function automatic bit m_ready(input bit s, input bit ar, input bit br);
      return s ? (qb.size() == 0 || br) : (qa.size() == 0 || ar);
   endfunction

   task automatic check_outputs();
      chk("a_valid", a_valid, qa.size() > 0);
      chk("a_data", a_data, la);
      chk("b_valid", b_valid, qb.size() > 0);
      chk("b_data", b_data, lb);
`ifdef DEMUX_CNT_EN
      chk("a_count", a_count, ca & 32'hFFFF);
      chk("b_count", b_count, cb & 32'hFFFF);
      chk("a_count_w2", a2_count, ca % 4);
      chk("b_count_w2", b2_count, cb % 4);
`endif
   endtask

   task automatic step(input bit v, input bit s, input logic [7:0] d, input bit ar, input bit br);
      @(negedge clk);
      in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
      #1;
      last_ir = m_ready(s, ar, br);
      chk("in_ready", in_ready, last_ir);
      last_acc = v && last_ir;
      @(posedge clk);
      if (qa.size() > 0 && ar) begin void'(qa.pop_front()); ca++; end
      if (qb.size() > 0 && br) begin void'(qb.pop_front()); cb++; end
      if (last_acc) begin
         if (s) begin qb.push_back(d); lb = d; end
         else begin qa.push_back(d); la = d; end
      end
      #1;
      check_outputs();
   endtask

   typedef struct {
      bit v, s; logic [7:0] d; bit ar, br;
      bit ir, av; logic [7:0] ad; bit bv; logic [7:0] bd;
   } vec_t;
   vec_t tbl[10];

   bit         cur_v = 0, cur_s = 0;
   logic [7:0] cur_d = '0;

   initial begin
      tbl[0] = '{1, 0, 8'h12, 1, 0, 1, 1, 8'h12, 0, 8'h00};
      tbl[1] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'h12, 0, 8'h00};
      tbl[2] = '{1, 0, 8'h34, 0, 0, 1, 1, 8'h34, 0, 8'h00};
      tbl[3] = '{1, 0, 8'h56, 0, 0, 0, 1, 8'h34, 0, 8'h00};
      tbl[4] = '{0, 0, 8'h56, 0, 0, 0, 1, 8'h34, 0, 8'h00};
      tbl[5] = '{1, 1, 8'h56, 0, 0, 1, 1, 8'h34, 1, 8'h56};
      tbl[6] = '{0, 1, 8'h00, 1, 1, 1, 0, 8'h34, 0, 8'h56};
      tbl[7] = '{1, 0, 8'hAA, 0, 0, 1, 1, 8'hAA, 0, 8'h56};
      tbl[8] = '{1, 0, 8'hBB, 1, 0, 1, 1, 8'hBB, 0, 8'h56};
      tbl[9] = '{0, 0, 8'h00, 1, 0, 1, 0, 8'hBB, 0, 8'h56};
      #12;
      chk("rst_in_ready", in_ready, 1);
      check_outputs();
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ar, tbl[i].br);
         chk($sformatf("tbl%0d_ir", i), last_ir, tbl[i].ir);
         chk($sformatf("tbl%0d_av", i), a_valid, tbl[i].av);
         chk($sformatf("tbl%0d_ad", i), a_data, tbl[i].ad);
         chk($sformatf("tbl%0d_bv", i), b_valid, tbl[i].bv);
         chk($sformatf("tbl%0d_bd", i), b_data, tbl[i].bd);
      end
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 8'(i), 1, 0);
         chk("stream_acc", last_acc, 1);
         chk("stream_a_data", a_data, i);
         chk("stream_a_valid", a_valid, 1);
      end
      for (int i = 0; i < 6; i++) step(1, i[0], 8'(8'h40 + i), 1, 1);
      step(0, 0, 8'h00, 1, 1);
      step(1, 0, 8'hC1, 0, 0);
      step(1, 1, 8'hC2, 0, 0);
      chk("pre_rst_both_full", {a_valid, b_valid}, 2'b11);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_a_valid", a_valid, 0);
      chk("async_b_valid", b_valid, 0);
      chk("async_a_data", a_data, 0);
      chk("async_b_data", b_data, 0);
      chk("async_in_ready", in_ready, 1);
      qa.delete(); qb.delete(); la = '0; lb = '0; ca = 0; cb = 0;
      check_outputs();
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!(cur_v && !last_acc)) begin
            cur_v = ($urandom % 4) != 0;
            cur_s = 1'($urandom);
            cur_d = 8'($urandom);
         end
         step(cur_v, cur_s, cur_d, ($urandom % 3) != 0, ($urandom % 3) != 0);
      end
      step(0, 0, 8'h00, 1, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/demux_stage.md
# demux_stage

Registered 1-to-2 demultiplexer with valid/ready handshaking. It steers one producer stream to one of two consumer channels: A when `in_sel`=0, B when `in_sel`=1. It is the inverse of the 2:1 data multiplexer on the Subleq datapath and routes bus results, such as memory read data versus ALU operand, to their destination. Each output channel has its own one-entry holding slot, so a stalled consumer blocks only traffic addressed to it.

## Interface
Parameters:
- `P_DATA`, 8, data width in bits.
- `P_CNT`, 16, transfer-counter width in bits (used only with `DEMUX_CNT_EN`).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input word offered.
- `in_ready`  out  1  input word accepted this cycle when `in_valid`=1.
- `in_sel`  in  1  destination: 0 = A, 1 = B.
- `in_data`  in  P_DATA  input word.
- `a_valid`  out  1  slot A holds a word.
- `a_ready`  in  1  consumer A takes the word.
- `a_data`  out  P_DATA  slot A word.
- `b_valid`, `b_ready`, `b_data`: same as the A ports, for channel B.
- `a_count`, `b_count`  out  P_CNT  completed output transfers per channel (present only with `DEMUX_CNT_EN`).

## Operation
- Each slot has two states:
  - EMPTY: valid=0.
  - FULL: valid=1, data held stable.
- Input transfer: `in_valid & in_ready` at a rising edge.
- Output transfer: `x_valid & x_ready` at a rising edge.
- `in_ready` = slot[`in_sel`] EMPTY, or slot[`in_sel`] FULL with `x_ready`=1 for that slot (pass-through refill).
- `in_ready` depends combinationally on `in_sel` and the selected `x_ready`. It never depends on the unselected channel.
- Slot transitions:
  - EMPTY→FULL: input transfer targeting the slot.
  - FULL→EMPTY: output transfer with no input transfer targeting the slot.
  - FULL→FULL with new data: output transfer and input transfer on the same edge.
- Only one slot can load per cycle. The other slot may drain on the same edge independently.
- `x_data` is registered and changes only on a load edge. While FULL and not drained it holds its value.
- Words to the same channel stay in order. No ordering is guaranteed between channels.
- Producer rule: `in_sel` and `in_data` must be stable while `in_valid`=1 and `in_ready`=0. A bench assertion checks this.
- Consumer rule: holding `x_ready`=1 while `x_valid`=0 has no effect.

## Timing
- Reset values: `a_valid`=`b_valid`=0, `a_data`=`b_data`=0, counters 0.
- `in_ready` is 1 out of reset, since both slots are EMPTY.
- Reset asserted mid-operation discards held words immediately (asynchronous). The first accept after reset deassertion is the first rising edge.
- Latency: a word accepted at edge N is visible on `x_valid`/`x_data` after edge N. Output transfer occurs at edge N+1 at the earliest.
- Throughput: one word per cycle to a single channel while its consumer holds ready. Alternating A/B traffic also sustains one word per cycle.
- Backpressure: a slot FULL with `x_ready`=0 deasserts `in_ready` only while `in_sel` addresses that slot.

## Configuration
- Macro `DEMUX_CNT_EN`.
- Defined:
  - `a_count` and `b_count` exist.
  - Each increments by 1 on every output transfer of its channel.
  - Each wraps modulo 2^P_CNT, from all-ones to 0.
  - Each resets to 0.
- Undefined: counter ports and logic are absent. Handshake behaviour is identical.

## Structure
- Shared package `subleq_pkg` holds:
  - `DEMUX_PORT_A`=1'b0 and `DEMUX_PORT_B`=1'b1 select constants, shared with the MUX select encoding.
  - The default data width constant.
- Sub-module `demux_slot`, instantiated twice. It contains:
  - the one-entry register (valid and data);
  - its load/drain logic;
  - its optional counter.
- Ports of `demux_slot`: `load`, `din`, `valid`, `ready`, `dout`, `count`.
- The top level contains only the select decode and the `in_ready` mux.

## Test plan
- Reset, then idle: `in_ready`=1, both valids 0, both data 0.
- Send 0x12 with `in_sel`=0, `a_ready`=1: `a_valid`=1, `a_data`=0x12 the cycle after accept. B stays 0. `a_count`=1 after the drain (DEMUX_CNT_EN).
- Stall A:
  - Stimulus: `a_ready`=0, send 0x34 to A, then offer 0x56 to A.
  - Required: `in_ready`=0 and `a_data` holds 0x34.
  - Then switch the offer to `in_sel`=1 with 0x56: accepted, `b_data`=0x56, A unaffected.
- Back-to-back A stream 0x01..0x08 with `a_ready`=1: one accept per cycle, outputs 0x01..0x08 in order, no bubbles.
- Pass-through refill: slot A FULL with 0xAA, `a_ready`=1, input 0xBB to A on the same edge. Required: 0xAA transferred, `a_data`=0xBB next cycle, `a_valid` stays 1.
- Async reset asserted mid-cycle while both slots are FULL: valids drop to 0 without a clock edge. Counters clear. Counter wrap is checked separately with `P_CNT`=2: after 4 drains, `count`=0.
